// File: rtl/router_pkt_tx.sv
// Packet transmitter toward a router input port: sends a header, then the payload, then a parity byte.
// Each byte is held on data_in until a cycle where the router is not busy.
module router_pkt_tx (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic [7:0] pl_data,
    output logic       pl_rd,
    input  logic       busy,
    output logic [7:0] data_in,
    output logic       pkt_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_PARITY  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] header_reg;
    logic [5:0] count_reg;
    logic [7:0] parity_reg;
    logic       cfg_err_reg;

    logic       cfg_ok;
    logic       accept;

    assign cfg_ok  = (pay_len != 6'd0) && (dest_addr != 2'd3);
    assign cfg_err = cfg_err_reg;

    // A byte is taken by the router on any transfer-state edge where it is not busy.
    assign accept = !busy && ((state_reg == S_HEADER) ||
                              (state_reg == S_PAYLOAD) ||
                              (state_reg == S_PARITY));

    always_comb begin
        state_next = state_reg;
        data_in    = 8'h00;
        pkt_valid  = 1'b0;
        pl_rd      = 1'b0;
        done       = 1'b0;
        tx_ready   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (start && cfg_ok)
                    state_next = S_HEADER;
            end
            S_HEADER: begin
                data_in   = header_reg;
                pkt_valid = 1'b1;
                if (accept)
                    state_next = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                data_in   = pl_data;
                pkt_valid = 1'b1;
                pl_rd     = !busy;
                if (accept && (count_reg == 6'd1))
                    state_next = S_PARITY;
            end
            S_PARITY: begin
                data_in = parity_reg;
                if (accept)
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg   <= S_IDLE;
            header_reg  <= 8'h00;
            count_reg   <= 6'd0;
            parity_reg  <= 8'h00;
            cfg_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cfg_err_reg <= (state_reg == S_IDLE) && start && !cfg_ok;
            if ((state_reg == S_IDLE) && start && cfg_ok) begin
                header_reg <= {pay_len, dest_addr};
                count_reg  <= pay_len;
                parity_reg <= 8'h00;
            end
            if (accept && ((state_reg == S_HEADER) || (state_reg == S_PAYLOAD)))
                parity_reg <= parity_reg ^ data_in;
            if (accept && (state_reg == S_PAYLOAD))
                count_reg <= count_reg - 6'd1;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: each started packet pushes its expected byte stream,
// and a negedge monitor pops one entry per accepted transfer cycle.
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic [7:0] pl_data;
    logic       pl_rd;
    logic       busy;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       tx_ready;
    logic       done;
    logic       cfg_err;

    router_pkt_tx dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .dest_addr (dest_addr),
        .pay_len   (pay_len),
        .pl_data   (pl_data),
        .pl_rd     (pl_rd),
        .busy      (busy),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       pv;
        logic       pl;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] src_mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    int         n_checks;
    int         n_bad;
    bit         mon_en;
    bit         done_due;

    // Show-ahead payload source; a reset discards anything not yet popped.
    assign pl_data = src_mem[rd_ptr];
    always @(posedge clock) begin
        if (!resetn)
            rd_ptr <= wr_ptr;
        else if (pl_rd)
            rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (!tx_ready && !done) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_xfer", 32'd1, 32'd0);
                end else begin
                    item_t it;
                    it = exp_q[0];
                    check_eq("data_in", {24'd0, data_in}, {24'd0, it.d});
                    check_eq("pkt_valid", {31'd0, pkt_valid}, {31'd0, it.pv});
                    check_eq("pl_rd", {31'd0, pl_rd}, {31'd0, it.pl && !busy});
                    if (!busy) begin
                        void'(exp_q.pop_front());
                        if (!it.pv) done_due = 1'b1;
                    end
                    $display("xfer data_in=%02h pv=%0b busy=%0b pl_rd=%0b", data_in, pkt_valid, busy, pl_rd);
                end
            end else begin
                check_eq("done", {31'd0, done}, {31'd0, done_due});
                if (done_due) $display("done pulse observed=%0b", done);
                done_due = 1'b0;
                check_eq("idle_pv", {31'd0, pkt_valid}, 32'd0);
                check_eq("idle_pl_rd", {31'd0, pl_rd}, 32'd0);
                check_eq("idle_data", {24'd0, data_in}, 32'd0);
            end
        end
    end

    // Called at a negedge while idle; returns 1 ns after the edge that samples start.
    task automatic start_pkt(input logic [1:0] d, input logic [5:0] n, input bit rand_pl);
        logic [7:0] par;
        logic [7:0] b;
        item_t      it;
        par = {n, d};
        it.d = {n, d}; it.pv = 1'b1; it.pl = 1'b0;
        exp_q.push_back(it);
        for (int i = 0; i < int'(n); i++) begin
            b = rand_pl ? 8'($urandom) : 8'(8'h11 * (i + 1));
            src_mem[wr_ptr] = b;
            wr_ptr = wr_ptr + 8'd1;
            par = par ^ b;
            it.d = b; it.pv = 1'b1; it.pl = 1'b1;
            exp_q.push_back(it);
        end
        it.d = par; it.pv = 1'b0; it.pl = 1'b0;
        exp_q.push_back(it);
        $display("start dest=%0d len=%0d parity=%02h", d, n, par);
        start = 1'b1; dest_addr = d; pay_len = n;
        @(posedge clock); #1;
        start = 1'b0;
        dest_addr = 2'($urandom);
        pay_len = 6'($urandom);
    endtask

    // Returns at a negedge where the packet has drained and the DUT is back in IDLE.
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(tx_ready && exp_q.size() == 0 && !done_due) && k < budget);
        check_eq("drain_timeout", {31'd0, tx_ready && exp_q.size() == 0}, 32'd1);
    endtask

    task automatic illegal_start(input logic [1:0] d, input logic [5:0] n);
        start = 1'b1; dest_addr = d; pay_len = n;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        $display("illegal start dest=%0d len=%0d cfg_err=%0b", d, n, cfg_err);
        check_eq("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        check_eq("cfg_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("cfg_pv", {31'd0, pkt_valid}, 32'd0);
        @(negedge clock);
        check_eq("cfg_err_once", {31'd0, cfg_err}, 32'd0);
        check_eq("cfg_stay_idle", {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        n_checks = 0; n_bad = 0; mon_en = 1'b0; done_due = 1'b0;
        wr_ptr = 8'd0;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        resetn = 1'b0; start = 1'b0; dest_addr = 2'd0; pay_len = 6'd0; busy = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("rst_pv", {31'd0, pkt_valid}, 32'd0);
        check_eq("rst_data", {24'd0, data_in}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);

        // Basic packet, no stalls: 0x0D, 0x11, 0x22, 0x33, parity.
        start_pkt(2'd1, 6'd3, 1'b0);
        wait_idle(50);

        // Header held for two busy cycles.
        start_pkt(2'd1, 6'd3, 1'b0);
        busy = 1'b1;
        repeat (2) @(posedge clock);
        #1 busy = 1'b0;
        wait_idle(50);

        // Single-byte payload stalled once on its only (last) byte.
        start_pkt(2'd0, 6'd1, 1'b1);
        @(posedge clock); #1;
        busy = 1'b1;
        @(posedge clock); #1;
        busy = 1'b0;
        wait_idle(50);

        illegal_start(2'd1, 6'd0);
        illegal_start(2'd3, 6'd5);

        // Maximum length with occasional random stalls.
        start_pkt(2'd2, 6'd63, 1'b1);
        for (int i = 0; i < 80; i++) begin
            busy = ($urandom_range(0, 3) == 0);
            @(posedge clock); #1;
        end
        busy = 1'b0;
        wait_idle(200);

        // Reset after two payload bytes have been accepted.
        start_pkt(2'd2, 6'd5, 1'b1);
        repeat (3) begin
            @(posedge clock); #1;
        end
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        $display("reset mid-payload tx_ready=%0b pv=%0b data_in=%02h", tx_ready, pkt_valid, data_in);
        check_eq("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("mid_rst_pv", {31'd0, pkt_valid}, 32'd0);
        check_eq("mid_rst_data", {24'd0, data_in}, 32'd0);
        check_eq("mid_rst_pl_rd", {31'd0, pl_rd}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        resetn = 1'b1;
        exp_q.delete();
        done_due = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        start_pkt(2'd1, 6'd4, 1'b1);
        wait_idle(50);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
